spi_frame_sequencer: RTL and testbench

Controller that sits directly behind the quad-SPI byte receiver and turns its raw byte stream into framed depth-map writes. It hunts for a two-byte sync header, sequences the following payload bytes into linear frame-buffer write addresses, and verifies an optional trailing checksum. It then reports frame completion or error to the display/processing logic. All outputs are registered, and the block owns the frame-buffer write port.

---
 rtl/spi_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: hunts a two-byte sync header, turns the payload into
// linear frame-buffer writes, and reports frame completion or error.
// Optional feature macro: SPI_FRAME_CHECKSUM_EN adds a trailing checksum byte
// (CHECK state and 8-bit running sum). When it is undefined, a frame ends
// with its last pixel.
module spi_frame_sequencer #(
  parameter int unsigned FRAME_W        = 64,
  parameter int unsigned FRAME_H        = 48,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 enable_in,
  input  logic [7:0]                           byte_in,
  input  logic                                 byte_valid_in,
  output logic [$clog2(FRAME_W*FRAME_H)-1:0]   addr_out,
  output logic [7:0]                           pixel_out,
  output logic                                 we_out,
  output logic                                 frame_done_out,
  output logic                                 frame_err_out,
  output logic [15:0]                          frame_count_out,
  output logic                                 busy_out
);

  localparam int unsigned NPIX   = FRAME_W * FRAME_H;
  localparam int unsigned ADDR_W = $clog2(NPIX);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD
`ifdef SPI_FRAME_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [TMO_W-1:0]    r_tmo;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_pixel;
  logic                r_we;
  logic                r_done;
  logic                r_err;
  logic [15:0]         r_count;
  logic                r_busy;

  logic                w_last_pixel;
  logic                w_tmo_hit;

  // Terminal-count decodes for the pixel index and the inter-byte idle counter
  always_comb begin
    w_last_pixel = (r_idx == ADDR_W'(NPIX - 1));
    w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  // Frame sequencer: state, counters and all registered outputs.
  // Priority inside a frame: enable drop aborts, then a valid byte, then the
  // timeout, so a byte arriving on the terminal count clears it silently.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
      r_sum   <= '0;
`endif
      r_addr  <= '0;
      r_pixel <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tmo <= '0;
        if (enable_in && byte_valid_in && (byte_in == SYNC0)) begin
          r_state <= S_HDR;
          r_busy  <= 1'b1;
        end
      end else if (!enable_in) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_tmo   <= '0;
      end else if (byte_valid_in) begin
        r_tmo <= '0;
        case (r_state)
          S_HDR: begin
            if (byte_in == SYNC1) begin
              r_state <= S_PAYLOAD;
              r_idx   <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
              r_sum   <= '0;
`endif
            end else if (byte_in != SYNC0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_PAYLOAD: begin
            r_we    <= 1'b1;
            r_addr  <= r_idx;
            r_pixel <= byte_in;
            r_idx   <= r_idx + 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
            r_sum   <= r_sum + byte_in;
            if (w_last_pixel) begin
              r_state <= S_CHECK;
            end
`else
            if (w_last_pixel) begin
              r_done  <= 1'b1;
              r_count <= r_count + 16'd1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
`endif
          end
`ifdef SPI_FRAME_CHECKSUM_EN
          S_CHECK: begin
            if (byte_in == r_sum) begin
              r_done  <= 1'b1;
              r_count <= r_count + 16'd1;
            end else begin
              r_err   <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`endif
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_tmo_hit) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_tmo   <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign addr_out        = r_addr;
  assign pixel_out       = r_pixel;
  assign we_out          = r_we;
  assign frame_done_out  = r_done;
  assign frame_err_out   = r_err;
  assign frame_count_out = r_count;
  assign busy_out        = r_busy;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Randomized self-checking bench for spi_frame_sequencer with a frame-level
// reference model (byte queue per frame attempt). Follows SPI_FRAME_CHECKSUM_EN.
module tb_spi_frame_sequencer;

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NPIX = FW * FH;
  localparam int TMO = 20;
  localparam logic [7:0] S0 = 8'hA5;
  localparam logic [7:0] S1 = 8'h5A;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic [2:0]  addr_out;
  logic [7:0]  pixel_out;
  logic        we_out;
  logic        frame_done_out;
  logic        frame_err_out;
  logic [15:0] frame_count_out;
  logic        busy_out;

  spi_frame_sequencer #(
    .FRAME_W(FW), .FRAME_H(FH), .SYNC0(S0), .SYNC1(S1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .byte_in(byte_in),
    .byte_valid_in(byte_valid_in), .addr_out(addr_out), .pixel_out(pixel_out),
    .we_out(we_out), .frame_done_out(frame_done_out), .frame_err_out(frame_err_out),
    .frame_count_out(frame_count_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_seen = 0;
  int n_done_seen = 0;
  int exp_frames = 0;

  // Reference model: a frame attempt is "active" after SYNC0, "synced" after
  // SYNC1; payload bytes collect in a queue whose length is the pixel index.
  bit        m_active, m_synced;
  int        m_idle, m_count;
  byte unsigned q[$];
  bit        e_we, e_done, e_err;
  int        e_addr, e_pix;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_synced = 0; m_idle = 0; m_count = 0; q.delete();
    e_we = 0; e_done = 0; e_err = 0; e_addr = 0; e_pix = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input logic [7:0] b);
    int s;
    e_we = 0; e_done = 0; e_err = 0;
    if (!m_active) begin
      m_idle = 0;
      if (en && v && b == S0) begin m_active = 1; m_synced = 0; end
    end else if (!en) begin
      m_active = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (!m_synced) begin
        if (b == S1) begin m_synced = 1; q.delete(); end
        else if (b != S0) m_active = 0;
      end else if (q.size() < NPIX) begin
        e_we = 1; e_addr = q.size(); e_pix = b;
        q.push_back(b);
        if (q.size() == NPIX && !CSUM) begin e_done = 1; m_count++; m_active = 0; end
      end else begin
        s = 0;
        foreach (q[i]) s += q[i];
        if (b == s % 256) begin e_done = 1; m_count++; end
        else e_err = 1;
        m_active = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin e_err = 1; m_active = 0; m_idle = 0; end
    end
  endtask

  task automatic compare_all();
    check_eq("we", we_out, e_we);
    check_eq("done", frame_done_out, e_done);
    check_eq("err", frame_err_out, e_err);
    check_eq("count", frame_count_out, m_count % 65536);
    check_eq("busy", busy_out, m_active);
    if (e_we) begin
      check_eq("addr", addr_out, e_addr);
      check_eq("pixel", pixel_out, e_pix);
    end
  endtask

  task automatic cycle(input bit en, input bit v, input logic [7:0] b);
    enable_in = en; byte_valid_in = v; byte_in = b;
    @(posedge clk_in);
    model_step(en, v, b);
    #1;
    compare_all();
    n_err_seen += int'(frame_err_out);
    n_done_seen += int'(frame_done_out);
    byte_valid_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, 1'b1, b);
  endtask

  // Pixels 01..08 (sum 0x24) with a chosen checksum byte when enabled
  task automatic send_std_frame(input logic [7:0] ck);
    send(S0); send(S1);
    for (int i = 1; i <= NPIX; i++) send(8'(i));
    if (CSUM) send(ck);
  endtask

  task automatic reset_now();
    rst_in = 1'b1;
    #2;
    check_eq("rst_we", we_out, 0);
    check_eq("rst_done", frame_done_out, 0);
    check_eq("rst_err", frame_err_out, 0);
    check_eq("rst_count", frame_count_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_addr", addr_out, 0);
    check_eq("rst_pixel", pixel_out, 0);
    model_reset();
    exp_frames = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    int nf, gap;
    logic [7:0] pix [NPIX];
    int s;
    rst_in = 1'b1; enable_in = 1'b0; byte_in = '0; byte_valid_in = 1'b0;
    model_reset();
    @(posedge clk_in); #1;
    reset_now();

    // Good frame
    n_done_seen = 0; n_err_seen = 0;
    send_std_frame(8'h24);
    exp_frames++;
    check_eq("good_count", frame_count_out, exp_frames);
    check_eq("good_done_pulses", n_done_seen, 1);
    check_eq("good_err_pulses", n_err_seen, 0);

    // Bad checksum (without checksum the 25 is plain idle traffic)
    n_done_seen = 0; n_err_seen = 0;
    send_std_frame(8'h25);
    if (!CSUM) send(8'h25);
    if (!CSUM) exp_frames++;
    cycle(1'b1, 1'b0, 8'h00);
    check_eq("bad_count", frame_count_out, exp_frames);
    check_eq("bad_err_pulses", n_err_seen, CSUM ? 1 : 0);
    check_eq("bad_busy", busy_out, 0);

    // Resync through junk and repeated SYNC0
    send(8'h33); send(S0);
    send_std_frame(8'h24);
    exp_frames++;
    check_eq("resync_count", frame_count_out, exp_frames);

    // Timeout after two pixels, then a good frame
    n_err_seen = 0;
    send(S0); send(S1); send(8'h01); send(8'h02);
    for (int i = 0; i < TMO; i++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("tmo_err_once", n_err_seen, 1);
    check_eq("tmo_busy", busy_out, 0);
    send_std_frame(8'h24);
    exp_frames++;
    check_eq("tmo_next_count", frame_count_out, exp_frames);

    // Abort by enable drop after three pixels
    n_err_seen = 0; n_done_seen = 0;
    send(S0); send(S1); send(8'h01); send(8'h02); send(8'h03);
    cycle(1'b0, 1'b1, 8'h04);
    check_eq("abort_busy", busy_out, 0);
    cycle(1'b1, 1'b0, 8'h00);
    check_eq("abort_pulses", n_err_seen + n_done_seen, 0);

    // Asynchronous reset mid-payload
    send(S0); send(S1); send(8'h11); send(8'h22);
    reset_now();

    // Trailing byte after a frame is idle traffic
    send_std_frame(8'h24);
    send(8'h77);
    cycle(1'b1, 1'b0, 8'h00);
    check_eq("trail_busy", busy_out, 0);

    // Randomized frames: junk, repeated sync, gaps, timeouts, bad sums, aborts
    for (int f = 0; f < 60; f++) begin
      nf = $urandom_range(0, 2);
      for (int i = 0; i < nf; i++) send(8'($urandom));
      send(S0);
      if ($urandom_range(0, 3) == 0) send(S0);
      if ($urandom_range(0, 9) == 0) send(8'h00);
      send(S1);
      s = 0;
      for (int i = 0; i < NPIX; i++) begin
        pix[i] = 8'($urandom);
        s += pix[i];
        gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 2, TMO + 1)
                                           : $urandom_range(0, 1);
        for (int g = 0; g < gap; g++) cycle(1'b1, 1'b0, 8'h00);
        if ($urandom_range(0, 49) == 0) cycle(1'b0, 1'b0, 8'h00);
        send(pix[i]);
      end
      send(($urandom_range(0, 2) == 0) ? 8'(s + 1) : 8'(s));
    end
    for (int i = 0; i < TMO + 2; i++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("final_busy", busy_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
